decompressor: RTL
=================

DECOMPRESSOR -- requirements
Module: decompressor

Interface
REQ-001 Parameter ActiveFrameWidth, 512, pixels per row (power of two, max 1024).
REQ-002 Parameter ActiveFrameHeight, 384, rows per frame.
REQ-003 Parameter PixelBitWidth, 16, pixel width in bits (RGB565).
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 i_byte  in  8  compressed byte at head of UART RX FIFO (FWFT).
REQ-007 i_empty  in  1  RX FIFO empty.
REQ-008 o_fetch  out  1  one-cycle pop of RX FIFO.
REQ-009 o_pixel  out  PixelBitWidth  decoded pixel.
REQ-010 o_valid  out  1  o_pixel valid; transfer when o_valid && i_ready.
REQ-011 i_ready  in  1  downstream accepts pixel.
REQ-012 o_row_end / o_frame_end  out  1 each  asserted with the last pixel of a row / of a frame.
REQ-013 o_err_count  out  8  reserved-tag error count.

Function
REQ-014 Reference pixel R(x) is the decoded pixel at column x of the previous row; R(x)=0 on row 0 of every frame.
REQ-015 Tag 0nnnnnnn (COPY) emits n+1 pixels equal to R(x), consuming 1 byte.
REQ-016 Tag 10dddddd (DELTA) emits one pixel R(x) + sign-extended d, modulo 2^PixelBitWidth.
REQ-017 Tag 11000000 (LITERAL) is followed by MSB byte then LSB byte; emits {MSB,LSB}.
REQ-018 Tags 11000001..11111111 are reserved; byte is dropped, no pixel emitted, decoding continues with the next byte as a tag.
REQ-019 FSM states: TAG (await byte), LIT_HI, LIT_LO, RUN (COPY emission), EMIT (single pixel); TAG->RUN/EMIT/LIT_HI per tag; LIT_HI->LIT_LO->EMIT; RUN/EMIT->TAG when done.
REQ-020 o_fetch asserts only when !i_empty and the FSM consumes the byte (TAG, LIT_HI, LIT_LO); never in RUN or EMIT.
REQ-021 In RUN, throughput is one pixel per cycle while i_ready=1; o_pixel/o_valid hold stable while i_ready=0.
REQ-022 Each accepted pixel is written to the line buffer at column x, overwriting R(x) after it was read; x increments.
REQ-023 x wraps from ActiveFrameWidth-1 to 0 with y+1; y wraps from ActiveFrameHeight-1 to 0 with o_frame_end.
REQ-024 A COPY run crossing a row boundary continues on the next row, using the new row's R(x).
REQ-025 Latency from o_fetch of a DELTA tag to o_valid is 2 cycles (1-cycle synchronous line-buffer read).
REQ-026 An empty FIFO in any byte-consuming state stalls without emitting; no timeout.

Reset
REQ-027 On RST: FSM=TAG; x=y=0; o_valid, o_fetch, o_row_end, o_frame_end=0; o_pixel=0; o_err_count=0.
REQ-028 Line-buffer contents are not reset; the row-0 zero-reference rule masks them.
REQ-029 RST mid-run discards the run in progress; the next byte is decoded as a tag at x=0, y=0.

Configuration
REQ-030 Macro DECOMPRESSOR_ERR_COUNT_EN defined: o_err_count increments on each reserved tag, saturating at 255.
REQ-031 Macro undefined: o_err_count is tied to 0 and no counter logic is built; reserved-tag dropping is unchanged.

Structure
REQ-032 Tag encodings, field widths and the zero reference belong in shared package codec_pkg, used also by Compressor.
REQ-033 Sub-module decomp_line_buffer: single-port-read/single-port-write RAM, ActiveFrameWidth x PixelBitWidth, synchronous read.

Verification
REQ-034 Reset, then byte 0x7F, i_ready=1 -> 128 pixels of 0x0000 at one per cycle, 1 fetch.
REQ-035 Row 0 literal 0xC0,0x12,0x34 at x=0; row 1 tag 0x81 at x=0 -> pixel 0x1235; tag 0xBF -> 0x1233 at x=1 against row-0 pixel 0x1234.
REQ-036 i_ready toggling 0/1 during a 0x0F COPY -> exactly 16 transfers, o_pixel stable while i_ready=0.
REQ-037 Byte 0xE5 then 0x80 -> no pixel from 0xE5, o_err_count=1 (with macro) or 0 (without), next pixel = R(x)+0.
REQ-038 Full frame of COPY tags -> o_row_end every 512th pixel, o_frame_end on pixel 196608, then x=y=0.
REQ-039 RST asserted mid-COPY -> o_valid=0 immediately, decoding restarts at x=0, y=0 on the next tag.

Source files
------------

// File: rtl/codec_pkg.sv
// -----------------------------------------------------------------------------
// codec_pkg -- definitions shared by the compressor and the decompressor.
//
// Byte-stream tag format:
//   0nnnnnnn  COPY     n+1 pixels equal to the reference pixel R(x)
//   10dddddd  DELTA    one pixel R(x) + sign-extended d
//   11000000  LITERAL  followed by MSB byte, then LSB byte
//   11000001..11111111 reserved (dropped by the decoder)
//
// The reference pixel R(x) is the pixel at the same column of the previous
// row; on row 0 of every frame it is the zero reference.
// -----------------------------------------------------------------------------
package codec_pkg;

  localparam int unsigned TAG_W     = 8;
  localparam int unsigned RUN_LEN_W = 7;   // COPY run-length field
  localparam int unsigned DELTA_W   = 6;   // DELTA signed field

  localparam logic [TAG_W-1:0] TAG_LITERAL = 8'hC0;

  // Replicated to the pixel width wherever a zero reference is needed.
  localparam logic ZERO_REF_BIT = 1'b0;

  typedef enum logic [1:0] {
    TK_COPY,
    TK_DELTA,
    TK_LITERAL,
    TK_RESERVED
  } tag_kind_t;

  typedef enum logic [2:0] {
    ST_TAG,
    ST_LIT_HI,
    ST_LIT_LO,
    ST_RUN,
    ST_EMIT
  } dec_state_t;

  function automatic tag_kind_t classify_tag(input logic [TAG_W-1:0] tag);
    if (!tag[7]) begin
      return TK_COPY;
    end else if (!tag[6]) begin
      return TK_DELTA;
    end else if (tag == TAG_LITERAL) begin
      return TK_LITERAL;
    end else begin
      return TK_RESERVED;
    end
  endfunction

endpackage

// File: rtl/decomp_line_buffer.sv
// -----------------------------------------------------------------------------
// decomp_line_buffer -- one row of decoded pixels, used as the reference row.
//
// Simple dual-port RAM (one write port, one read port), Depth x Width, with a
// registered read: o_rd_data shows the word addressed one cycle earlier.
// A read and write to the same address in one cycle returns the old word.
// Contents are not reset.
//
// Ports:
//   clk        clock
//   i_wr_en    write strobe
//   i_wr_addr  write column
//   i_wr_data  write pixel
//   i_rd_addr  read column
//   o_rd_data  registered read pixel
// -----------------------------------------------------------------------------
module decomp_line_buffer #(
  parameter  int Depth = 512,
  parameter  int Width = 16,
  localparam int AW    = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [Width-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [Width-1:0] o_rd_data
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/decompressor.sv
// -----------------------------------------------------------------------------
// decompressor -- decodes the COPY / DELTA / LITERAL byte stream read from a
// first-word-fall-through UART RX FIFO into a raster of pixels.
//
// Optional feature: define DECOMPRESSOR_ERR_COUNT_EN to build a saturating
// counter of reserved tags on o_err_count; otherwise o_err_count is 0.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          asynchronous active-high reset
//   i_byte       byte at the head of the RX FIFO
//   i_empty      RX FIFO empty
//   o_fetch      one-cycle pop of the RX FIFO
//   o_pixel      decoded pixel
//   o_valid      o_pixel valid; a transfer happens when o_valid && i_ready
//   i_ready      downstream accepts the pixel
//   o_row_end    with the last pixel of a row
//   o_frame_end  with the last pixel of a frame
//   o_err_count  reserved-tag count
//
// Pipeline: the line buffer is read continuously at the column of the next
// pixel to be generated, so its registered output always holds R(x) for the
// current column. A generated pixel goes into a single output register; it is
// written back to the line buffer when the downstream accepts it.
// -----------------------------------------------------------------------------
module decompressor
  import codec_pkg::*;
#(
  parameter int ActiveFrameWidth  = 512,
  parameter int ActiveFrameHeight = 384,
  parameter int PixelBitWidth     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               i_byte,
  input  logic                     i_empty,
  output logic                     o_fetch,
  output logic [PixelBitWidth-1:0] o_pixel,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_row_end,
  output logic                     o_frame_end,
  output logic [7:0]               o_err_count
);

  localparam int XW = $clog2(ActiveFrameWidth);
  localparam int YW = (ActiveFrameHeight > 1) ? $clog2(ActiveFrameHeight) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(ActiveFrameWidth - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ActiveFrameHeight - 1);

  dec_state_t r_state, w_state_next;

  logic [XW-1:0]            r_x, w_x_next;
  logic [YW-1:0]            r_y, w_y_next;
  logic [RUN_LEN_W-1:0]     r_run_cnt, w_run_cnt_next;
  logic [7:0]               r_lit_hi, w_lit_hi_next;
  logic [PixelBitWidth-1:0] r_emit_val, w_emit_val_next;
  logic                     r_emit_lit, w_emit_lit_next;

  logic [PixelBitWidth-1:0] r_pixel;
  logic                     r_valid;
  logic                     r_row_end;
  logic                     r_frame_end;
  logic [XW-1:0]            r_out_x;

  logic                     w_fetch;
  logic                     w_adv;
  logic                     w_accept;
  logic                     w_gen;
  logic [PixelBitWidth-1:0] w_gen_pixel;
  logic [PixelBitWidth-1:0] w_rd_data;
  logic [PixelBitWidth-1:0] w_ref;

  // Output register is free, or is being emptied this cycle.
  assign w_adv    = !r_valid || i_ready;
  assign w_accept = r_valid && i_ready;

  // Row 0 of a frame uses the zero reference; this also masks whatever the
  // (unreset) line buffer holds after power-up or reset.
  assign w_ref = (r_y == '0) ? {PixelBitWidth{ZERO_REF_BIT}} : w_rd_data;

  decomp_line_buffer #(
    .Depth (ActiveFrameWidth),
    .Width (PixelBitWidth)
  ) u_line_buffer (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_out_x),
    .i_wr_data (r_pixel),
    .i_rd_addr (w_x_next),
    .o_rd_data (w_rd_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_TAG;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, byte consumption and pixel generation
  always_comb begin
    w_state_next    = r_state;
    w_run_cnt_next  = r_run_cnt;
    w_lit_hi_next   = r_lit_hi;
    w_emit_val_next = r_emit_val;
    w_emit_lit_next = r_emit_lit;
    w_fetch         = 1'b0;
    w_gen           = 1'b0;
    w_gen_pixel     = w_ref;

    case (r_state)
      ST_TAG: begin
        if (!i_empty) begin
          w_fetch = 1'b1;
          case (classify_tag(i_byte))
            TK_COPY: begin
              w_run_cnt_next = i_byte[RUN_LEN_W-1:0];
              w_state_next   = ST_RUN;
            end
            TK_DELTA: begin
              w_emit_val_next = {{(PixelBitWidth-DELTA_W){i_byte[DELTA_W-1]}},
                                 i_byte[DELTA_W-1:0]};
              w_emit_lit_next = 1'b0;
              w_state_next    = ST_EMIT;
            end
            TK_LITERAL: begin
              w_state_next = ST_LIT_HI;
            end
            default: begin
              // Reserved tag: byte is popped and dropped, stay in TAG.
            end
          endcase
        end
      end

      ST_LIT_HI: begin
        if (!i_empty) begin
          w_fetch       = 1'b1;
          w_lit_hi_next = i_byte;
          w_state_next  = ST_LIT_LO;
        end
      end

      ST_LIT_LO: begin
        if (!i_empty) begin
          w_fetch         = 1'b1;
          w_emit_val_next = PixelBitWidth'({r_lit_hi, i_byte});
          w_emit_lit_next = 1'b1;
          w_state_next    = ST_EMIT;
        end
      end

      ST_RUN: begin
        if (w_adv) begin
          w_gen       = 1'b1;
          w_gen_pixel = w_ref;
          if (r_run_cnt == '0) begin
            w_state_next = ST_TAG;
          end else begin
            w_run_cnt_next = r_run_cnt - RUN_LEN_W'(1);
          end
        end
      end

      ST_EMIT: begin
        if (w_adv) begin
          w_gen        = 1'b1;
          w_gen_pixel  = r_emit_lit ? r_emit_val : (w_ref + r_emit_val);
          w_state_next = ST_TAG;
        end
      end

      default: begin
        w_state_next = ST_TAG;
      end
    endcase
  end

  // Raster position of the next pixel to be generated
  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_gen) begin
      if (r_x == X_LAST) begin
        w_x_next = '0;
        w_y_next = (r_y == Y_LAST) ? '0 : (r_y + YW'(1));
      end else begin
        w_x_next = r_x + XW'(1);
      end
    end
  end

  // Decoder working registers and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_run_cnt   <= '0;
      r_lit_hi    <= '0;
      r_emit_val  <= '0;
      r_emit_lit  <= 1'b0;
      r_pixel     <= '0;
      r_valid     <= 1'b0;
      r_row_end   <= 1'b0;
      r_frame_end <= 1'b0;
      r_out_x     <= '0;
    end else begin
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_run_cnt  <= w_run_cnt_next;
      r_lit_hi   <= w_lit_hi_next;
      r_emit_val <= w_emit_val_next;
      r_emit_lit <= w_emit_lit_next;
      if (w_gen) begin
        r_pixel     <= w_gen_pixel;
        r_valid     <= 1'b1;
        r_row_end   <= (r_x == X_LAST);
        r_frame_end <= (r_x == X_LAST) && (r_y == Y_LAST);
        r_out_x     <= r_x;
      end else if (w_accept) begin
        r_valid     <= 1'b0;
        r_row_end   <= 1'b0;
        r_frame_end <= 1'b0;
      end
    end
  end

  assign o_fetch     = w_fetch && !rst;
  assign o_pixel     = r_pixel;
  assign o_valid     = r_valid;
  assign o_row_end   = r_row_end;
  assign o_frame_end = r_frame_end;

`ifdef DECOMPRESSOR_ERR_COUNT_EN
  logic       w_reserved;
  logic [7:0] r_err_count;

  assign w_reserved = (r_state == ST_TAG) && !i_empty &&
                      (classify_tag(i_byte) == TK_RESERVED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_reserved && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign o_err_count = r_err_count;
`else
  assign o_err_count = '0;
`endif

endmodule
